algo_3ror1w_refr_sched: RTL

Refresh scheduler for the banked 3-read-or-1-write memory core. It generates periodic refresh obligations, tracks how many are owed, and issues each one to the next (virtual bank, refresh bank) pair in rotation, only in cycles when that virtual bank is not being read or written. When the owed count saturates, it stalls host traffic and forces the refresh. It sits between the host command decode and the t1 physical-bank interface, driving t1_refrB/t1_bankB.

---
 rtl/algo_3ror1w_refr_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/algo_3ror1w_refr_sched.sv
// Refresh scheduler for the banked 3R-or-1W core: accrues periodic refresh obligations and
// issues them round-robin over (vbank, rbank) in conflict-free cycles, stalling the host at saturation.
module algo_3ror1w_refr_sched #(
  parameter int NUMRDPT = 3,
  parameter int NUMVBNK = 4,
  parameter int BITVBNK = 2,
  parameter int NUMRBNK = 2,
  parameter int BITRBNK = 1,
  parameter int REFFREQ = 6,
  parameter int REFFRHF = 0,
  parameter int MAXPEND = 4,
  parameter int BITPEND = 3,
  parameter int INITCYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         refr,
  input  logic [NUMRDPT-1:0]           read,
  input  logic [NUMRDPT*BITVBNK-1:0]   rd_vbnk,
  input  logic                         write,
  input  logic [BITVBNK-1:0]           wr_vbnk,
  output logic                         ready,
  output logic                         refr_stall,
  output logic [NUMVBNK-1:0]           t1_refrB,
  output logic [NUMVBNK*BITRBNK-1:0]   t1_bankB,
  output logic [BITPEND-1:0]           pend_cnt,
  output logic                         refr_err
);

  localparam int BITTMR  = $clog2(REFFREQ + 2);
  localparam int BITINIT = $clog2(INITCYC + 1);
  localparam int BITSUM  = BITPEND + 2;

  typedef enum logic {INIT, ACTIVE} state_t;

  state_t                       state_q;
  logic [BITINIT-1:0]           init_q;
  logic [BITTMR-1:0]            timer_q;
  logic                         half_q;
  logic [BITVBNK-1:0]           vbnk_q;
  logic [BITRBNK-1:0]           rbnk_q;
  logic [BITPEND-1:0]           pend_q;
  logic                         stall_q;
  logic                         err_q;
  logic                         ready_q;
  logic [NUMVBNK-1:0]           refrb_q;
  logic [NUMVBNK*BITRBNK-1:0]   bankb_q;

  logic                         active;
  logic [BITTMR-1:0]            period_m1;
  logic                         tick;
  logic                         conflict;
  logic                         issue;
  logic [BITSUM-1:0]            sum;
  logic                         over;
  logic [BITPEND-1:0]           pend_d;

  always_comb begin
    active    = (state_q == ACTIVE);
    period_m1 = BITTMR'(REFFREQ - 1);
    // With the half-cycle option, every other period is one cycle longer.
    if ((REFFRHF != 0) && half_q) period_m1 = BITTMR'(REFFREQ);
    tick = active && (timer_q == period_m1);

    conflict = 1'b0;
    for (int i = 0; i < NUMRDPT; i++) begin
      if (read[i] && (rd_vbnk[i*BITVBNK +: BITVBNK] == vbnk_q)) conflict = 1'b1;
    end
    if (write && (wr_vbnk == vbnk_q)) conflict = 1'b1;

    issue = active && (pend_q != '0) && (stall_q || !conflict);

    // issue implies pend_q > 0, so the subtraction never underflows.
    sum    = BITSUM'(pend_q) + BITSUM'(tick) + BITSUM'(refr && active) - BITSUM'(issue);
    over   = (sum > BITSUM'(MAXPEND));
    pend_d = over ? BITPEND'(MAXPEND) : sum[BITPEND-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      init_q  <= '0;
      timer_q <= '0;
      half_q  <= 1'b0;
      vbnk_q  <= '0;
      rbnk_q  <= '0;
      pend_q  <= '0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      refrb_q <= '0;
      bankb_q <= '0;
    end else begin
      refrb_q <= '0;
      if (issue) begin
        refrb_q <= NUMVBNK'(1) << vbnk_q;
        bankb_q <= {NUMVBNK{rbnk_q}};
        if (vbnk_q == BITVBNK'(NUMVBNK - 1)) begin
          vbnk_q <= '0;
          rbnk_q <= (rbnk_q == BITRBNK'(NUMRBNK - 1)) ? '0 : rbnk_q + 1'b1;
        end else begin
          vbnk_q <= vbnk_q + 1'b1;
        end
      end

      case (state_q)
        INIT: begin
          init_q <= init_q + 1'b1;
          if (init_q == BITINIT'(INITCYC - 1)) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (tick) begin
            timer_q <= '0;
            half_q  <= ~half_q;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
          pend_q  <= pend_d;
          stall_q <= (pend_d == BITPEND'(MAXPEND));
          if (over) err_q <= 1'b1;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign ready      = ready_q;
  assign refr_stall = stall_q;
  assign t1_refrB   = refrb_q;
  assign t1_bankB   = bankb_q;
  assign pend_cnt   = pend_q;
  assign refr_err   = err_q;

endmodule
